stage_wb: RTL and testbench
===========================

Name: stage_wb

Overview:
- Write-back stage; consumes the TL-stage pipeline register outputs (wb_*).
- Commits register writes, raises I-TLB/D-TLB miss exceptions, and executes iret, jumps and taken branches by redirecting fetch.
- Performs privileged TLB writes.
- Buffers committed stores in a small FIFO that drains into the D-cache STORE interface.

Parameters:
- N_THREADS, 4, hardware threads; width of thread id is $clog2(N_THREADS).
- SB_DEPTH, 4, store-buffer entries (power of two, >=2).
- EXC_VECTOR, 32'h0000_2000, fetch address on exception.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wb_thread  in  TW  thread id
- wb_isvalid  in  1  instruction valid
- wb_itlb_miss, wb_dtlb_miss  in  1  each  TLB miss flags
- wb_dst  in  5  destination register
- wb_pc  in  32  instruction PC
- wb_r2  in  32  store data / TLB-write PPN source
- wb_data  in  32  ALU result, load data, store paddr (low 20 bits) or faulting vaddr
- wb_isequal  in  1  branch compare result
- wb_mul  in  32  multiplier result
- wb_flag_mul, wb_flag_reg, wb_flag_jump, wb_flag_branch, wb_flag_iret, wb_flag_store, wb_flag_isbyte  in  1  each  decode flags
- wb_flag_tlbwrite  in  2  0 none, 1 ITLB, 2 DTLB
- store_ready  in  1  D-cache can accept a store this cycle
- rf_we  out  1  register write enable
- rf_thread  out  TW  register write thread
- rf_dst  out  5  register write index
- rf_data  out  32  register write data
- redirect_en  out  1  fetch redirect
- redirect_thread  out  TW  redirect thread
- redirect_pc  out  32  redirect target
- itlbwrite_en  out  1  I-TLB write enable
- tlbwrite_en  out  1  D-TLB write enable
- tlbwrite_vpn  out  20  virtual page number
- tlbwrite_ppn  out  8  physical page number
- store_en  out  1  store to D-cache
- store_isbyte  out  1  byte store
- store_addr  out  20  physical address
- store_data  out  32  store data
- sb_full  out  1  store buffer full
- sb_empty  out  1  store buffer empty
- rm_mode  out  N_THREADS  per-thread rm4 (1 = supervisor)

Behaviour:
- Latency: every output except sb_full/sb_empty/rm_mode is registered, one cycle after the inputs. sb_full, sb_empty and rm_mode are direct decodes of state.
- Reset values: all enables 0; data, address and pc outputs 0; sb_empty 1, sb_full 0. Per thread: rm0 = rm1 = rm2 = 0, rm4 = 1. FIFO pointers and count are 0.
- Reset mid-operation clears the FIFO; pending stores are discarded.
- Exceptions are checked regardless of wb_isvalid; the first matching case in priority order is taken:
  1. wb_itlb_miss: rm0 <= wb_pc, rm1 <= wb_pc, rm2 <= 1, rm4 <= 1; redirect to EXC_VECTOR.
  2. wb_dtlb_miss: rm0 <= wb_pc, rm1 <= wb_data, rm2 <= 2, rm4 <= 1; redirect to EXC_VECTOR.
- Store rejected: wb_isvalid & wb_flag_store & FIFO full (count == SB_DEPTH, same-cycle dequeue ignored) -> redirect to wb_pc (replay), no other effect.
- Otherwise, when wb_isvalid, the first matching case in priority order is taken:
  1. wb_flag_iret: rm4 <= 0; redirect to rm0.
  2. wb_flag_jump: redirect to wb_data.
  3. wb_flag_branch & wb_isequal: redirect to wb_data.
- Register write:
  - Enable: rf_we = wb_isvalid & wb_flag_reg & no exception/reject.
  - Data: rf_data = wb_flag_mul ? wb_mul : wb_data.
- TLB write:
  - Enable condition: wb_isvalid, rm4 of wb_thread == 1, no exception. Selects itlbwrite_en or tlbwrite_en by wb_flag_tlbwrite.
  - Fields: vpn = wb_data[31:12], ppn = wb_r2[7:0].
  - In user mode the write is silently ignored.
- Store buffer:
  - Enqueue: on wb_isvalid & wb_flag_store & no exception & not full. Entry is {isbyte, wb_data[19:0], wb_r2}.
  - Dequeue: when count > 0 & store_ready; the head entry appears on store_* with store_en = 1 next cycle. Stores drain in order.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Pointers wrap modulo SB_DEPTH.
- Invalid instructions with no miss flag have no effect.

Test Plan:
- Reset mid-drain with 3 entries queued, store_ready=1 -> store_en=0 the cycle after reset; sb_empty=1; rm_mode=4'b1111.
- Valid ALU op, thread 2, wb_dst=7, wb_data=32'h1234, flag_reg=1 -> next cycle rf_we=1, rf_thread=2, rf_dst=7, rf_data=32'h1234; with flag_mul=1 and wb_mul=32'h99 -> rf_data=32'h99.
- D-TLB miss, thread 1, pc=32'h1000, wb_data=32'hABCD_E000 -> redirect_en=1, redirect_pc=32'h2000, rf_we=0; a following iret on thread 1 -> redirect_pc=32'h1000 and rm_mode[1]=0.
- 4 stores with store_ready=0 -> sb_full=1; 5th store at pc=32'h40 -> redirect_pc=32'h40, not enqueued. Raise store_ready -> 4 consecutive store_en pulses in order with correct addr/data/isbyte.
- tlbwrite DTLB in supervisor mode, wb_data=32'h0040_3000, wb_r2=8'h12 -> tlbwrite_en=1, vpn=20'h00403, ppn=8'h12. Same in user mode -> no enable.
- Branch with isequal=1, wb_data=32'h80 -> redirect_pc=32'h80. Same with isequal=0 -> redirect_en=0.

Source files
------------

// File: rtl/stage_wb.sv
// stage_wb: write-back stage of the threaded pipeline.
//   Commits register writes, takes I-TLB/D-TLB miss exceptions, and redirects
//   fetch for iret, jumps and taken branches. It also performs privileged TLB
//   writes, and buffers committed stores in a small FIFO that drains into the
//   D-cache store port.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wb_*              TL-stage pipeline register outputs
//   store_ready       D-cache accepts a store this cycle
//   rf_*              register-file write port (registered)
//   redirect_*        fetch redirect (registered)
//   itlbwrite_en, tlbwrite_*  TLB write port (registered)
//   store_*           D-cache store port (registered)
//   sb_full, sb_empty store-buffer status (decoded from state)
//   rm_mode           per-thread supervisor bit (rm4)
module stage_wb #(
    parameter int          N_THREADS  = 4,
    parameter int          SB_DEPTH   = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
    localparam int         TW         = $clog2(N_THREADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TW-1:0]        wb_thread,
    input  logic                 wb_isvalid,
    input  logic                 wb_itlb_miss,
    input  logic                 wb_dtlb_miss,
    input  logic [4:0]           wb_dst,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_r2,
    input  logic [31:0]          wb_data,
    input  logic                 wb_isequal,
    input  logic [31:0]          wb_mul,
    input  logic                 wb_flag_mul,
    input  logic                 wb_flag_reg,
    input  logic                 wb_flag_jump,
    input  logic                 wb_flag_branch,
    input  logic                 wb_flag_iret,
    input  logic                 wb_flag_store,
    input  logic                 wb_flag_isbyte,
    input  logic [1:0]           wb_flag_tlbwrite,
    input  logic                 store_ready,
    output logic                 rf_we,
    output logic [TW-1:0]        rf_thread,
    output logic [4:0]           rf_dst,
    output logic [31:0]          rf_data,
    output logic                 redirect_en,
    output logic [TW-1:0]        redirect_thread,
    output logic [31:0]          redirect_pc,
    output logic                 itlbwrite_en,
    output logic                 tlbwrite_en,
    output logic [19:0]          tlbwrite_vpn,
    output logic [7:0]           tlbwrite_ppn,
    output logic                 store_en,
    output logic                 store_isbyte,
    output logic [19:0]          store_addr,
    output logic [31:0]          store_data,
    output logic                 sb_full,
    output logic                 sb_empty,
    output logic [N_THREADS-1:0] rm_mode
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    // Per-thread exception state: rm0 return pc, rm1 fault address, rm2 cause.
    logic [31:0]          rm0 [N_THREADS];
    logic [31:0]          rm1 [N_THREADS];
    logic [1:0]           rm2 [N_THREADS];
    logic [N_THREADS-1:0] rm4;

    // Store buffer entry layout: {isbyte, paddr[19:0], data[31:0]}.
    logic [52:0]   sb_mem [SB_DEPTH];
    logic [PW-1:0] sb_wptr;
    logic [PW-1:0] sb_rptr;
    logic [CW-1:0] sb_count;

    logic exc, reject, enq, deq, tlb_ok;
    logic        redir_nxt;
    logic [31:0] redir_pc_nxt;

    assign sb_full  = (sb_count == CW'(SB_DEPTH));
    assign sb_empty = (sb_count == '0);
    assign rm_mode  = rm4;

    assign exc    = wb_itlb_miss | wb_dtlb_miss;
    // A full buffer rejects a store without looking at a same-cycle dequeue,
    // keeping the full decode off the store_ready path.
    assign reject = ~exc & wb_isvalid & wb_flag_store & sb_full;
    assign enq    = ~exc & wb_isvalid & wb_flag_store & ~sb_full;
    assign deq    = ~sb_empty & store_ready;
    assign tlb_ok = ~exc & ~reject & wb_isvalid & rm4[wb_thread];

    always_comb begin
        redir_nxt    = 1'b0;
        redir_pc_nxt = 32'h0;
        if (exc) begin
            redir_nxt    = 1'b1;
            redir_pc_nxt = EXC_VECTOR;
        end else if (reject) begin
            redir_nxt    = 1'b1;
            redir_pc_nxt = wb_pc;
        end else if (wb_isvalid) begin
            if (wb_flag_iret) begin
                redir_nxt    = 1'b1;
                redir_pc_nxt = rm0[wb_thread];
            end else if (wb_flag_jump || (wb_flag_branch && wb_isequal)) begin
                redir_nxt    = 1'b1;
                redir_pc_nxt = wb_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we           <= 1'b0;
            rf_thread       <= '0;
            rf_dst          <= '0;
            rf_data         <= '0;
            redirect_en     <= 1'b0;
            redirect_thread <= '0;
            redirect_pc     <= '0;
            itlbwrite_en    <= 1'b0;
            tlbwrite_en     <= 1'b0;
            tlbwrite_vpn    <= '0;
            tlbwrite_ppn    <= '0;
            store_en        <= 1'b0;
            store_isbyte    <= 1'b0;
            store_addr      <= '0;
            store_data      <= '0;
            sb_wptr         <= '0;
            sb_rptr         <= '0;
            sb_count        <= '0;
            rm4             <= '1;
            for (int t = 0; t < N_THREADS; t++) begin
                rm0[t] <= '0;
                rm1[t] <= '0;
                rm2[t] <= '0;
            end
        end else begin
            rf_we     <= wb_isvalid & wb_flag_reg & ~exc & ~reject;
            rf_thread <= wb_thread;
            rf_dst    <= wb_dst;
            rf_data   <= wb_flag_mul ? wb_mul : wb_data;

            redirect_en     <= redir_nxt;
            redirect_thread <= wb_thread;
            redirect_pc     <= redir_pc_nxt;

            itlbwrite_en <= tlb_ok & (wb_flag_tlbwrite == 2'd1);
            tlbwrite_en  <= tlb_ok & (wb_flag_tlbwrite == 2'd2);
            tlbwrite_vpn <= wb_data[31:12];
            tlbwrite_ppn <= wb_r2[7:0];

            if (wb_itlb_miss) begin
                rm0[wb_thread] <= wb_pc;
                rm1[wb_thread] <= wb_pc;
                rm2[wb_thread] <= 2'd1;
                rm4[wb_thread] <= 1'b1;
            end else if (wb_dtlb_miss) begin
                rm0[wb_thread] <= wb_pc;
                rm1[wb_thread] <= wb_data;
                rm2[wb_thread] <= 2'd2;
                rm4[wb_thread] <= 1'b1;
            end else if (!reject && wb_isvalid && wb_flag_iret) begin
                rm4[wb_thread] <= 1'b0;
            end

            store_en <= deq;
            if (deq) begin
                {store_isbyte, store_addr, store_data} <= sb_mem[sb_rptr];
                sb_rptr <= sb_rptr + 1'b1;
            end
            if (enq)
                sb_wptr <= sb_wptr + 1'b1;
            if (enq && !deq)
                sb_count <= sb_count + 1'b1;
            else if (deq && !enq)
                sb_count <= sb_count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (enq)
            sb_mem[sb_wptr] <= {wb_flag_isbyte, wb_data[19:0], wb_r2};
    end

    // rm1/rm2 are architectural state with no read port in this stage.
    logic [N_THREADS-1:0] unused_rm;
    for (genvar g = 0; g < N_THREADS; g++) begin : g_unused
        assign unused_rm[g] = ^{rm1[g], rm2[g]};
    end

endmodule

// File: tb/tb_stage_wb.sv
module tb_stage_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_thread;
    logic        wb_isvalid, wb_itlb_miss, wb_dtlb_miss;
    logic [4:0]  wb_dst;
    logic [31:0] wb_pc, wb_r2, wb_data, wb_mul;
    logic        wb_isequal, wb_flag_mul, wb_flag_reg, wb_flag_jump, wb_flag_branch;
    logic        wb_flag_iret, wb_flag_store, wb_flag_isbyte;
    logic [1:0]  wb_flag_tlbwrite;
    logic        store_ready;
    logic        rf_we, redirect_en, itlbwrite_en, tlbwrite_en;
    logic [1:0]  rf_thread, redirect_thread;
    logic [4:0]  rf_dst;
    logic [31:0] rf_data, redirect_pc, store_data;
    logic [19:0] tlbwrite_vpn, store_addr;
    logic [7:0]  tlbwrite_ppn;
    logic        store_en, store_isbyte, sb_full, sb_empty;
    logic [3:0]  rm_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stage_wb dut (
        .clk(clk), .rst(rst),
        .wb_thread(wb_thread), .wb_isvalid(wb_isvalid),
        .wb_itlb_miss(wb_itlb_miss), .wb_dtlb_miss(wb_dtlb_miss),
        .wb_dst(wb_dst), .wb_pc(wb_pc), .wb_r2(wb_r2), .wb_data(wb_data),
        .wb_isequal(wb_isequal), .wb_mul(wb_mul),
        .wb_flag_mul(wb_flag_mul), .wb_flag_reg(wb_flag_reg),
        .wb_flag_jump(wb_flag_jump), .wb_flag_branch(wb_flag_branch),
        .wb_flag_iret(wb_flag_iret), .wb_flag_store(wb_flag_store),
        .wb_flag_isbyte(wb_flag_isbyte), .wb_flag_tlbwrite(wb_flag_tlbwrite),
        .store_ready(store_ready),
        .rf_we(rf_we), .rf_thread(rf_thread), .rf_dst(rf_dst), .rf_data(rf_data),
        .redirect_en(redirect_en), .redirect_thread(redirect_thread),
        .redirect_pc(redirect_pc),
        .itlbwrite_en(itlbwrite_en), .tlbwrite_en(tlbwrite_en),
        .tlbwrite_vpn(tlbwrite_vpn), .tlbwrite_ppn(tlbwrite_ppn),
        .store_en(store_en), .store_isbyte(store_isbyte),
        .store_addr(store_addr), .store_data(store_data),
        .sb_full(sb_full), .sb_empty(sb_empty), .rm_mode(rm_mode)
    );

    typedef struct {
        logic [1:0]  thread;
        logic        valid, itlb, dtlb;
        logic [4:0]  dst;
        logic [31:0] pc, data, r2, mul;
        logic        fmul, freg, fjump, fbranch, iseq, firet;
        logic [1:0]  tlbw;
        logic        e_we;
        logic [31:0] e_rdata;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_itw, e_dtw;
        logic [3:0]  e_rm;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wb_thread = 0; wb_isvalid = 0; wb_itlb_miss = 0; wb_dtlb_miss = 0;
        wb_dst = 0; wb_pc = 0; wb_r2 = 0; wb_data = 0; wb_mul = 0; wb_isequal = 0;
        wb_flag_mul = 0; wb_flag_reg = 0; wb_flag_jump = 0; wb_flag_branch = 0;
        wb_flag_iret = 0; wb_flag_store = 0; wb_flag_isbyte = 0; wb_flag_tlbwrite = 0;
    endtask

    task automatic push_store(input int i);
        wb_isvalid = 1; wb_flag_store = 1; wb_thread = 0;
        wb_pc = 32'h300 + 32'(i * 4);
        wb_data = 32'hFFF1_0000 + 32'(i * 4);
        wb_r2 = 32'hCAFE_0000 + 32'(i);
        wb_flag_isbyte = i[0];
    endtask

    initial begin
        //            thr vl it dt dst pc          data           r2     mul    fm fr fj fb eq ir tw  we rdata     rd rpc        iw dw rm
        vecs[0]  = '{2, 1, 0, 0, 7,  32'h100,  32'h1234,      0,     0,     0, 1, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0,         0, 0, 4'hF};
        vecs[1]  = '{2, 1, 0, 0, 7,  32'h104,  32'h1234,      0,     32'h99,1, 1, 0, 0, 0, 0, 0, 1, 32'h99,   0, 0,         0, 0, 4'hF};
        vecs[2]  = '{1, 1, 0, 1, 3,  32'h1000, 32'hABCD_E000, 0,     0,     0, 1, 0, 0, 0, 0, 0, 0, 0,        1, 32'h2000,  0, 0, 4'hF};
        vecs[3]  = '{1, 1, 0, 0, 0,  32'h1004, 0,             0,     0,     0, 0, 0, 0, 0, 1, 0, 0, 0,        1, 32'h1000,  0, 0, 4'hD};
        vecs[4]  = '{0, 1, 0, 0, 0,  32'h200,  32'h0040_3000, 32'h12,0,     0, 0, 0, 0, 0, 0, 2, 0, 0,        0, 0,         0, 1, 4'hD};
        vecs[5]  = '{1, 1, 0, 0, 0,  32'h204,  32'h0040_3000, 32'h12,0,     0, 0, 0, 0, 0, 0, 2, 0, 0,        0, 0,         0, 0, 4'hD};
        vecs[6]  = '{0, 1, 0, 0, 0,  32'h208,  32'h80,        0,     0,     0, 0, 0, 1, 1, 0, 0, 0, 0,        1, 32'h80,    0, 0, 4'hD};
        vecs[7]  = '{0, 1, 0, 0, 0,  32'h20C,  32'h80,        0,     0,     0, 0, 0, 1, 0, 0, 0, 0, 0,        0, 0,         0, 0, 4'hD};
        vecs[8]  = '{2, 1, 0, 0, 0,  32'h210,  32'h500,       0,     0,     0, 0, 1, 0, 0, 0, 0, 0, 0,        1, 32'h500,   0, 0, 4'hD};
        vecs[9]  = '{3, 0, 1, 0, 4,  32'h3000, 32'h77,        0,     0,     0, 1, 0, 0, 0, 0, 0, 0, 0,        1, 32'h2000,  0, 0, 4'hD};
        vecs[10] = '{3, 1, 0, 0, 0,  32'h3004, 0,             0,     0,     0, 0, 0, 0, 0, 1, 0, 0, 0,        1, 32'h3000,  0, 0, 4'h5};
        vecs[11] = '{0, 0, 0, 0, 9,  32'h400,  32'h700,       0,     0,     0, 1, 1, 0, 0, 0, 1, 0, 0,        0, 0,         0, 0, 4'h5};
        vecs[12] = '{0, 1, 0, 0, 0,  32'h404,  32'hFFFF_F000, 32'h3C,0,     0, 0, 0, 0, 0, 0, 1, 0, 0,        0, 0,         1, 0, 4'h5};
        vecs[13] = '{3, 1, 1, 1, 2,  32'h3100, 32'h55,        0,     0,     0, 1, 0, 0, 0, 0, 0, 0, 0,        1, 32'h2000,  0, 0, 4'hD};
        vecs[14] = '{2, 1, 0, 0, 31, 32'h500,  32'h600,       0,     0,     0, 1, 1, 0, 0, 0, 0, 1, 32'h600,  1, 32'h600,   0, 0, 4'hD};

        clr();
        store_ready = 0;
        rst = 1;
        tick(); tick();
        chk("reset rf_we", 32'(rf_we), 0);
        chk("reset redirect_en", 32'(redirect_en), 0);
        chk("reset redirect_pc", redirect_pc, 0);
        chk("reset store_en", 32'(store_en), 0);
        chk("reset sb_empty", 32'(sb_empty), 1);
        chk("reset sb_full", 32'(sb_full), 0);
        chk("reset rm_mode", 32'(rm_mode), 32'hF);
        rst = 0;
        tick();

        for (int i = 0; i < 15; i++) begin
            wb_thread = vecs[i].thread; wb_isvalid = vecs[i].valid;
            wb_itlb_miss = vecs[i].itlb; wb_dtlb_miss = vecs[i].dtlb;
            wb_dst = vecs[i].dst; wb_pc = vecs[i].pc; wb_data = vecs[i].data;
            wb_r2 = vecs[i].r2; wb_mul = vecs[i].mul; wb_flag_mul = vecs[i].fmul;
            wb_flag_reg = vecs[i].freg; wb_flag_jump = vecs[i].fjump;
            wb_flag_branch = vecs[i].fbranch; wb_isequal = vecs[i].iseq;
            wb_flag_iret = vecs[i].firet; wb_flag_tlbwrite = vecs[i].tlbw;
            tick();
            chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d rf_data", i), rf_data, vecs[i].e_rdata);
                chk($sformatf("v%0d rf_dst", i), 32'(rf_dst), 32'(vecs[i].dst));
                chk($sformatf("v%0d rf_thread", i), 32'(rf_thread), 32'(vecs[i].thread));
            end
            chk($sformatf("v%0d redirect_en", i), 32'(redirect_en), 32'(vecs[i].e_redir));
            if (vecs[i].e_redir) begin
                chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
                chk($sformatf("v%0d redirect_thread", i), 32'(redirect_thread), 32'(vecs[i].thread));
            end
            chk($sformatf("v%0d itlbwrite_en", i), 32'(itlbwrite_en), 32'(vecs[i].e_itw));
            chk($sformatf("v%0d tlbwrite_en", i), 32'(tlbwrite_en), 32'(vecs[i].e_dtw));
            if (vecs[i].e_itw || vecs[i].e_dtw) begin
                chk($sformatf("v%0d vpn", i), 32'(tlbwrite_vpn), 32'(vecs[i].data[31:12]));
                chk($sformatf("v%0d ppn", i), 32'(tlbwrite_ppn), 32'(vecs[i].r2[7:0]));
            end
            chk($sformatf("v%0d rm_mode", i), 32'(rm_mode), 32'(vecs[i].e_rm));
        end

        // Fill the store buffer with the D-cache stalled, then overflow it.
        clr();
        for (int i = 0; i < 4; i++) begin
            push_store(i);
            tick();
            chk($sformatf("fill%0d sb_full", i), 32'(sb_full), (i == 3) ? 1 : 0);
            chk($sformatf("fill%0d sb_empty", i), 32'(sb_empty), 0);
            chk($sformatf("fill%0d redirect_en", i), 32'(redirect_en), 0);
        end
        push_store(4);
        wb_pc = 32'h40;
        tick();
        chk("reject redirect_en", 32'(redirect_en), 1);
        chk("reject redirect_pc", redirect_pc, 32'h40);
        chk("reject sb_full", 32'(sb_full), 1);
        chk("reject store_en", 32'(store_en), 0);
        clr();
        store_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain%0d store_en", i), 32'(store_en), 1);
            chk($sformatf("drain%0d store_addr", i), 32'(store_addr), 32'h1_0000 + 32'(i * 4));
            chk($sformatf("drain%0d store_data", i), store_data, 32'hCAFE_0000 + 32'(i));
            chk($sformatf("drain%0d store_isbyte", i), 32'(store_isbyte), 32'(i % 2));
        end
        tick();
        chk("drained store_en", 32'(store_en), 0);
        chk("drained sb_empty", 32'(sb_empty), 1);

        // Simultaneous enqueue/dequeue with one entry queued keeps the count.
        store_ready = 0;
        push_store(0);
        tick();
        store_ready = 1;
        push_store(1);
        tick();
        chk("enqdeq store_en", 32'(store_en), 1);
        chk("enqdeq store_addr", 32'(store_addr), 32'h1_0000);
        chk("enqdeq sb_empty", 32'(sb_empty), 0);
        clr();
        tick();
        chk("enqdeq second store_addr", 32'(store_addr), 32'h1_0004);
        tick();
        chk("enqdeq final sb_empty", 32'(sb_empty), 1);

        // Reset while draining three queued stores; rm_mode also returns to 1111.
        store_ready = 0;
        for (int i = 0; i < 3; i++) begin
            push_store(i);
            tick();
        end
        clr();
        store_ready = 1;
        tick();
        chk("middrain store_en", 32'(store_en), 1);
        rst = 1;
        tick();
        rst = 0;
        tick();
        chk("postrst store_en", 32'(store_en), 0);
        chk("postrst sb_empty", 32'(sb_empty), 1);
        chk("postrst rm_mode", 32'(rm_mode), 32'hF);
        tick();
        chk("postrst2 store_en", 32'(store_en), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
